// File: rtl/srl_fifo.sv
`default_nettype none
// ============================================================================
// srl_fifo : 16-deep first-word-fall-through FIFO built on a shift array,
//            with sticky overflow/underflow flags.      Rev 1.0
// ============================================================================
module srl_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [4:0]       count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 16;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_req;
    logic             rd_req;
    logic             wr_ok;
    logic             rd_ok;
    logic [3:0]       rd_idx;

    // Unknown enables count as inactive.
    assign wr_req = (wr_en === 1'b1);
    assign rd_req = (rd_en === 1'b1);

    assign empty  = (count == 5'd0);
    assign full   = (count == 5'd16);

    assign rd_ok  = rd_req && !empty;
    assign wr_ok  = wr_req && (!full || rd_ok);

    // Newest word sits at entry 0, so the oldest is at count-1.
    assign rd_idx = 4'(count - 5'd1);
    assign dout   = empty ? '0 : mem[rd_idx];

    // No reset and no parallel load, so this maps onto addressable shift primitives.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 5'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count <= count + 5'd1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 5'd1;
            end
            if (wr_req && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/srl_fifo.md
SRL_FIFO -- requirements
Module: srl_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 Parameter DEPTH is fixed at 16 entries; the block SHALL NOT expose it as a parameter.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  reset; synchronous, active-low.
REQ-005 WR_EN  input  1  write request; DIN is captured when accepted.
REQ-006 DIN  input  WIDTH  write data.
REQ-007 RD_EN  input  1  read request; pops the word currently on DOUT when accepted.
REQ-008 DOUT  output  WIDTH  oldest stored word (first-word fall-through).
REQ-009 EMPTY  output  1  high when COUNT = 0.
REQ-010 FULL  output  1  high when COUNT = 16.
REQ-011 COUNT  output  5  number of stored words, 0..16.
REQ-012 OVERFLOW  output  1  sticky flag; a write was rejected.
REQ-013 UNDERFLOW  output  1  sticky flag; a read was rejected.

Function
REQ-014 Storage SHALL be a 16 x WIDTH shift array: on an accepted write, entry[0] <= DIN and entry[i] <= entry[i-1] for i = 1..15.
REQ-015 The array SHALL have no reset and no parallel load, so it maps onto 16-deep addressable shift primitives.
REQ-016 The read address SHALL be COUNT-1, so DOUT = entry[COUNT-1] combinationally when COUNT > 0.
REQ-017 DOUT SHALL be all-zero when EMPTY = 1.
REQ-018 A write SHALL be accepted when WR_EN = 1 and either FULL = 0 or an accepted read occurs in the same cycle.
REQ-019 A read SHALL be accepted when RD_EN = 1 and EMPTY = 0.
REQ-020 COUNT update, write only: COUNT +1.
REQ-021 COUNT update, read only: COUNT -1.
REQ-022 COUNT update, both accepted: COUNT unchanged while the array shifts.
REQ-023 COUNT update, neither accepted: COUNT holds.
REQ-024 Simultaneous read and write at COUNT = 16: both SHALL be accepted, COUNT stays 16, and OVERFLOW SHALL NOT be set.
REQ-025 Simultaneous read and write at COUNT = 0: the write SHALL be accepted, the read SHALL be rejected, COUNT becomes 1, and UNDERFLOW SHALL be set.
REQ-026 WR_EN = 1 while FULL = 1 with no accepted read: the array and COUNT SHALL be unchanged, and OVERFLOW SHALL be set on the next edge.
REQ-027 RD_EN = 1 while EMPTY = 1: COUNT SHALL be unchanged, and UNDERFLOW SHALL be set on the next edge.
REQ-028 OVERFLOW and UNDERFLOW SHALL remain set until reset.
REQ-029 EMPTY and FULL SHALL be decoded from the registered COUNT with no extra cycle of latency.
REQ-030 Write-to-read latency: a word written into an empty FIFO SHALL appear on DOUT, with EMPTY = 0, in the cycle after the write edge.
REQ-031 COUNT SHALL never exceed 16 or wrap below 0 under any input sequence.
REQ-032 X or Z on WR_EN or RD_EN SHALL be treated as inactive (case-equality test).

Reset
REQ-033 When RST_N = 0 at a rising CLK edge, COUNT SHALL be 0 after that edge.
REQ-034 When RST_N = 0 at a rising CLK edge, EMPTY SHALL be 1 and FULL SHALL be 0 after that edge.
REQ-035 When RST_N = 0 at a rising CLK edge, OVERFLOW and UNDERFLOW SHALL be 0 after that edge.
REQ-036 When RST_N = 0 at a rising CLK edge, DOUT SHALL be 0 after that edge.
REQ-037 While RST_N = 0, WR_EN and RD_EN SHALL be ignored.
REQ-038 Array contents need not be cleared on reset; stale data SHALL NOT be visible, because COUNT = 0 forces DOUT to 0.
REQ-039 Reset asserted mid-stream SHALL discard all stored words; the first word written after reset release SHALL be the first word read.
REQ-040 Before the first reset all outputs are undefined; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-041 Fill/drain (WIDTH = 8): write 0x01..0x10 on 16 consecutive cycles -> FULL = 1, COUNT = 16; then read 16 times -> DOUT sequence is 0x01..0x10, then EMPTY = 1 and DOUT = 0x00.
REQ-042 Overflow: at COUNT = 16, write 0xAA with RD_EN = 0 -> COUNT stays 16, OVERFLOW = 1, and draining yields 0x01..0x10 with no 0xAA.
REQ-043 Underflow and simultaneous at empty: at COUNT = 0, assert RD_EN with WR_EN and DIN = 0x55 -> COUNT = 1, DOUT = 0x55, UNDERFLOW = 1.
REQ-044 Simultaneous at full: at COUNT = 16 holding 0x01..0x10, read and write 0x77 together -> COUNT = 16, OVERFLOW = 0, DOUT = 0x02, and 0x77 is read last.
REQ-045 Mid-stream reset: write 0x11, 0x22, 0x33, assert RST_N = 0 for 1 cycle, then write 0x44 -> COUNT = 1, DOUT = 0x44, both sticky flags 0.
REQ-046 Random: 10,000 cycles of random WR_EN/RD_EN/DIN against a reference queue model -> DOUT, COUNT, EMPTY, FULL and the flags match on every cycle.
